cpu_player: RTL and testbench
=============================

Name: cpu_player

Overview:
- Opponent-side generator for the tug-of-war game, the computer player.
- Produces button-like press events that the game core consumes exactly as it consumes the human KEY[0] press (level input, one point per rising edge).
- Difficulty comes from SW[8:0]: a higher value gives more frequent presses.
- Instantiated inside game beside the human input conditioner. It drives the "right player" press input to the playfield logic.

Parameters:
- LFSR_W, 10, width of the pseudo-random register (fixed 10; taps defined for 10 only).
- TICK_DIV, 1, clock cycles between random samples (>=1).
- HOLD_CYCLES, 1, cycles cpu_key stays high per press (>=1).
- GAP_CYCLES, 1, minimum cycles cpu_key stays low after a press (>=1).

Ports:
- clk  input  1  system clock
- reset  input  1  synchronous, active-high reset
- SW  input  9  difficulty threshold
- freeze  input  1  game over / round hold from the game core; suppresses presses
- cpu_key  output  1  registered button level, same semantics as a human key
- cpu_press  output  1  registered one-cycle pulse, high on the cycle cpu_key rises
- press_count  output  8  only present with CPU_STATS_EN

Behaviour:
- One clock, clk. reset is synchronous and active-high.
- Reset values: lfsr=0, divider=0, state=IDLE, cpu_key=0, cpu_press=0, press_count=0.
- LFSR:
  - Free-running every cycle except during reset.
  - XNOR Fibonacci: next = {lfsr[8:0], ~(lfsr[9]^lfsr[6])}.
  - All-zero is legal; the lock state 10'h3FF is unreachable from reset.
  - Sequence after reset: 0, 1, 3, 7, 15, ...
- Divider:
  - Counts 0..TICK_DIV-1 and wraps.
  - tick=1 when count==TICK_DIV-1.
  - TICK_DIV=1 gives tick every cycle.
- Hit: tick && (lfsr < {1'b0,SW}), 10-bit unsigned compare on the current registered lfsr.
  - SW=0 never hits.
  - SW=9'h1FF hits about 50%.
- FSM states: IDLE, PRESS, RELEASE.
  - IDLE: hit && !freeze goes to PRESS. On the next edge cpu_key=1 and cpu_press=1 (latency 1 cycle from the hit cycle). The hold counter loads HOLD_CYCLES-1.
  - PRESS: cpu_key=1 and cpu_press=0 after the first cycle. The counter decrements. At 0, go to RELEASE with cpu_key=0 and the gap counter loaded with GAP_CYCLES-1.
  - RELEASE: cpu_key=0. The counter decrements. At 0, go to IDLE.
  - Ticks and hits in PRESS or RELEASE are discarded, not queued.
- Minimum rising-edge spacing is HOLD_CYCLES+GAP_CYCLES+1 cycles.
- freeze:
  - Highest priority after reset.
  - In any state, the next edge forces IDLE with cpu_key=0 and cpu_press=0.
  - LFSR and divider keep running.
  - On freeze deassert, normal operation resumes at the next hit.
- Reset mid-press: cpu_key drops on the reset edge and the LFSR restarts at 0.
- SW changes take effect on the next tick compare. There is no latching.

Optional Feature:
- Macro: CPU_STATS_EN.
- Defined:
  - press_count port exists.
  - 8-bit counter increments on each cpu_press and saturates at 255.
  - Cleared by reset only; freeze does not clear it.
- Undefined: the port and the counter are absent. All other behaviour is identical.

Decomposition:
- Package cpu_player_pkg:
  - state enum (IDLE, PRESS, RELEASE)
  - LFSR_W
  - tap positions (9, 6)
  - LFSR reset value 10'h000
  - lock state 10'h3FF
- Sub-module cpu_lfsr: clk, reset, q[9:0], free-running XNOR LFSR. It is reusable by other game variants.
- The FSM, divider and compare stay in cpu_player.

Test Plan:
1. Reset sequence: reset=1 for 1 cycle, SW=0, then release. Required: lfsr reads 0, 1, 3, 7, 15 on consecutive cycles; cpu_key=0 and cpu_press=0 throughout.
2. Zero difficulty: SW=9'h000, run 300 cycles. Required: cpu_key and cpu_press are never high.
3. Max difficulty: SW=9'h1FF with defaults, 100 cycles. Required:
   - first cpu_press one cycle after the first cycle where lfsr<511;
   - every pulse is exactly 1 cycle and coincides with a cpu_key rise;
   - cpu_key high exactly 1 cycle;
   - rising edges at least 3 cycles apart.
4. Freeze mid-press: HOLD_CYCLES=4, SW=9'h1FF, assert freeze on the 2nd PRESS cycle for 20 cycles. Required: cpu_key=0 on the next edge and no cpu_press while frozen; presses resume after deassert.
5. Reset mid-press: HOLD_CYCLES=4, reset pulsed during PRESS. Required: cpu_key=0 on that edge and the lfsr sequence restarts 0, 1, 3.
6. CPU_STATS_EN with SW=9'h1FF. Required: press_count equals the counted cpu_press pulses while below 255, and holds at 255 after more than 255 presses.

Source files
------------

// File: rtl/cpu_player_pkg.sv
// Shared definitions for the tug-of-war computer player: FSM states,
// LFSR geometry, reset and lock values, and the LFSR step function.
package cpu_player_pkg;

    localparam int LFSR_W = 10;
    localparam int TAP_HI = 9;
    localparam int TAP_LO = 6;

    localparam logic [LFSR_W-1:0] LFSR_RESET = 10'h000;
    localparam logic [LFSR_W-1:0] LFSR_LOCK  = 10'h3FF;

    typedef enum logic [1:0] {
        IDLE,
        PRESS,
        RELEASE
    } state_t;

    // XNOR feedback keeps all-zero legal, so reset can start the sequence at 0
    function automatic logic [LFSR_W-1:0] lfsrNext(input logic [LFSR_W-1:0] cur);
        return {cur[LFSR_W-2:0], ~(cur[TAP_HI] ^ cur[TAP_LO])};
    endfunction

endpackage

// File: rtl/cpu_lfsr.sv
// Free-running 10-bit XNOR Fibonacci LFSR, reusable by other game variants.
// Starts at 0 after reset; the 10'h3FF lock state is unreachable from there.
module cpu_lfsr
    import cpu_player_pkg::*;
(
    input  logic              clk,
    input  logic              reset,
    output logic [LFSR_W-1:0] q
);

    // Advance one step every cycle; only reset holds it at the start value
    always_ff @(posedge clk) begin
        if (reset) begin
            q <= LFSR_RESET;
        end else begin
            q <= lfsrNext(q);
        end
    end

endmodule

// File: rtl/cpu_player.sv
// Computer opponent for tug-of-war: turns an LFSR-vs-difficulty compare
// into button-like press events (cpu_key level plus one-cycle cpu_press).
// Optional feature macro: CPU_STATS_EN adds the saturating press_count port.
module cpu_player #(
    parameter int LFSR_W      = 10,
    parameter int TICK_DIV    = 1,
    parameter int HOLD_CYCLES = 1,
    parameter int GAP_CYCLES  = 1
) (
    input  logic       clk,
    input  logic       reset,
    input  logic [8:0] SW,
    input  logic       freeze,
    output logic       cpu_key,
    output logic       cpu_press
`ifdef CPU_STATS_EN
    ,
    output logic [7:0] press_count
`endif
);
    import cpu_player_pkg::*;

    localparam int DIV_W   = (TICK_DIV > 1) ? $clog2(TICK_DIV) : 1;
    localparam int CNT_MAX = (HOLD_CYCLES > GAP_CYCLES) ? HOLD_CYCLES : GAP_CYCLES;
    localparam int CNT_W   = (CNT_MAX > 1) ? $clog2(CNT_MAX) : 1;

    logic [LFSR_W-1:0] lfsr_q;
    logic [DIV_W-1:0]  divCnt_q, divCnt_d;
    logic              tick;
    logic              hit;
    state_t            state_q, state_d;
    logic [CNT_W-1:0]  phaseCnt_q, phaseCnt_d;
    logic              cpuKey_q, cpuKey_d;
    logic              cpuPress_q, cpuPress_d;

    cpu_lfsr u_lfsr (
        .clk   (clk),
        .reset (reset),
        .q     (lfsr_q)
    );

    // Sample divider: tick marks the cycles on which a random draw is taken
    always_comb begin
        tick     = (divCnt_q == DIV_W'(TICK_DIV - 1));
        divCnt_d = tick ? '0 : divCnt_q + 1'b1;
        hit      = tick && (lfsr_q < {1'b0, SW});
    end

    // Press shaping FSM: hold the key, then enforce a gap; freeze overrides all
    always_comb begin
        state_d    = state_q;
        phaseCnt_d = phaseCnt_q;
        cpuKey_d   = 1'b0;
        cpuPress_d = 1'b0;
        case (state_q)
            IDLE: begin
                if (hit) begin
                    state_d    = PRESS;
                    phaseCnt_d = CNT_W'(HOLD_CYCLES - 1);
                    cpuKey_d   = 1'b1;
                    cpuPress_d = 1'b1;
                end
            end
            PRESS: begin
                if (phaseCnt_q == '0) begin
                    state_d    = RELEASE;
                    phaseCnt_d = CNT_W'(GAP_CYCLES - 1);
                end else begin
                    phaseCnt_d = phaseCnt_q - 1'b1;
                    cpuKey_d   = 1'b1;
                end
            end
            RELEASE: begin
                if (phaseCnt_q == '0) begin
                    state_d = IDLE;
                end else begin
                    phaseCnt_d = phaseCnt_q - 1'b1;
                end
            end
            default: begin
                state_d = IDLE;
            end
        endcase
        if (freeze) begin
            state_d    = IDLE;
            cpuKey_d   = 1'b0;
            cpuPress_d = 1'b0;
        end
    end

    // State, divider and registered outputs; reset drops the key immediately
    always_ff @(posedge clk) begin
        if (reset) begin
            state_q    <= IDLE;
            phaseCnt_q <= '0;
            divCnt_q   <= '0;
            cpuKey_q   <= 1'b0;
            cpuPress_q <= 1'b0;
        end else begin
            state_q    <= state_d;
            phaseCnt_q <= phaseCnt_d;
            divCnt_q   <= divCnt_d;
            cpuKey_q   <= cpuKey_d;
            cpuPress_q <= cpuPress_d;
        end
    end

    assign cpu_key   = cpuKey_q;
    assign cpu_press = cpuPress_q;

`ifdef CPU_STATS_EN
    logic [7:0] pressCount_q;

    // Count presses in step with the cpu_press pulse, saturating at 255
    always_ff @(posedge clk) begin
        if (reset) begin
            pressCount_q <= 8'd0;
        end else if (cpuPress_d && (pressCount_q != 8'hFF)) begin
            pressCount_q <= pressCount_q + 8'd1;
        end
    end

    assign press_count = pressCount_q;
`endif

endmodule

// File: tb/tb_cpu_player.sv
// Self-checking bench for cpu_player: a hand-computed cycle table plus
// directed sequences for freeze, reset mid-press and press statistics.
// Optional feature macro: CPU_STATS_EN enables the press_count checks.
module tb_cpu_player;
    import cpu_player_pkg::*;

    logic       clk;
    logic       reset;
    logic [8:0] sw;
    logic       freeze;
    logic       cpuKey, cpuPress;
    logic       cpuKey4, cpuPress4;
`ifdef CPU_STATS_EN
    logic [7:0] pressCount, pressCount4;
`endif

    int testsRun    = 0;
    int testsFailed = 0;

    typedef struct {
        logic [8:0] sw;
        logic       frz;
        int         expLfsr;
        logic       expKey;
        logic       expPress;
    } vec_t;

    vec_t tbl[21];

    cpu_player dut (
        .clk       (clk),
        .reset     (reset),
        .SW        (sw),
        .freeze    (freeze),
        .cpu_key   (cpuKey),
        .cpu_press (cpuPress)
`ifdef CPU_STATS_EN
        ,
        .press_count (pressCount)
`endif
    );

    cpu_player #(.HOLD_CYCLES(4)) dut4 (
        .clk       (clk),
        .reset     (reset),
        .SW        (sw),
        .freeze    (freeze),
        .cpu_key   (cpuKey4),
        .cpu_press (cpuPress4)
`ifdef CPU_STATS_EN
        ,
        .press_count (pressCount4)
`endif
    );

    // Free-running 10 ns clock
    initial clk = 1'b0;
    always #5 clk = ~clk;

    task automatic step();
        @(posedge clk);
        @(negedge clk);
    endtask

    task automatic applyStimulus(input logic [8:0] s, input logic f);
        sw     = s;
        freeze = f;
    endtask

    task automatic checkOutput(input string name, input int actual, input int expected);
        testsRun++;
        if (actual != expected) begin
            testsFailed++;
            $display("[TB] FAIL %s: got %0d, expected %0d", name, actual, expected);
        end
    endtask

    task automatic doReset(input logic [8:0] s);
        reset = 1'b1;
        applyStimulus(s, 1'b0);
        step();
        checkOutput("resetLfsr", int'(dut.lfsr_q), 0);
        checkOutput("resetKey", cpuKey, 0);
        checkOutput("resetPress", cpuPress, 0);
        reset = 1'b0;
    endtask

    // Main test sequence
    initial begin
        int lfsrSeq[4];
        int prevKey, lastRise, pulses, found, width;

        reset  = 1'b1;
        sw     = 9'h000;
        freeze = 1'b0;

        // Cycle-by-cycle table after reset; entry i drives cycle i, checks cycle i+1
        tbl[0]  = '{9'h1FF, 1'b0,    1, 1'b1, 1'b1};
        tbl[1]  = '{9'h1FF, 1'b0,    3, 1'b0, 1'b0};
        tbl[2]  = '{9'h1FF, 1'b0,    7, 1'b0, 1'b0};
        tbl[3]  = '{9'h007, 1'b0,   15, 1'b0, 1'b0};
        tbl[4]  = '{9'h010, 1'b0,   31, 1'b1, 1'b1};
        tbl[5]  = '{9'h1FF, 1'b0,   63, 1'b0, 1'b0};
        tbl[6]  = '{9'h1FF, 1'b0,  127, 1'b0, 1'b0};
        tbl[7]  = '{9'h1FF, 1'b1,  254, 1'b0, 1'b0};
        tbl[8]  = '{9'h1FF, 1'b0,  508, 1'b1, 1'b1};
        tbl[9]  = '{9'h1FF, 1'b1, 1016, 1'b0, 1'b0};
        tbl[10] = '{9'h1FF, 1'b0, 1009, 1'b0, 1'b0};
        tbl[11] = '{9'h1FF, 1'b0,  995, 1'b0, 1'b0};
        tbl[12] = '{9'h1FF, 1'b0,  967, 1'b0, 1'b0};
        tbl[13] = '{9'h1FF, 1'b0,  911, 1'b0, 1'b0};
        tbl[14] = '{9'h1FF, 1'b0,  798, 1'b0, 1'b0};
        tbl[15] = '{9'h1FF, 1'b0,  572, 1'b0, 1'b0};
        tbl[16] = '{9'h1FF, 1'b0,  120, 1'b0, 1'b0};
        tbl[17] = '{9'h000, 1'b0,  240, 1'b0, 1'b0};
        tbl[18] = '{9'h0F1, 1'b0,  480, 1'b1, 1'b1};
        tbl[19] = '{9'h1FF, 1'b0,  960, 1'b0, 1'b0};
        tbl[20] = '{9'h1FF, 1'b0,  897, 1'b0, 1'b0};

        lfsrSeq[0] = 1;
        lfsrSeq[1] = 3;
        lfsrSeq[2] = 7;
        lfsrSeq[3] = 15;

        // Reset sequence and zero difficulty
        doReset(9'h000);
        for (int i = 0; i < 4; i++) begin
            step();
            checkOutput("seqLfsr", int'(dut.lfsr_q), lfsrSeq[i]);
            checkOutput("seqKey", cpuKey, 0);
            checkOutput("seqPress", cpuPress, 0);
        end
        for (int i = 0; i < 300; i++) begin
            step();
            checkOutput("zeroKey", cpuKey, 0);
            checkOutput("zeroPress", cpuPress, 0);
        end

        // Table-driven vectors
        doReset(9'h1FF);
        for (int i = 0; i < 21; i++) begin
            applyStimulus(tbl[i].sw, tbl[i].frz);
            step();
            checkOutput($sformatf("vec%0d_lfsr", i), int'(dut.lfsr_q), tbl[i].expLfsr);
            checkOutput($sformatf("vec%0d_key", i), cpuKey, tbl[i].expKey);
            checkOutput($sformatf("vec%0d_press", i), cpuPress, tbl[i].expPress);
        end

        // Max difficulty pulse properties
        doReset(9'h1FF);
        prevKey  = 0;
        lastRise = -1;
        for (int cyc = 1; cyc <= 100; cyc++) begin
            step();
            checkOutput("pulseIsRise", cpuPress, int'(cpuKey && !prevKey));
            checkOutput("keyWidth", int'(cpuKey && prevKey), 0);
            checkOutput("noLock", int'(dut.lfsr_q == LFSR_LOCK), 0);
            if (cpuKey && !prevKey) begin
                if (lastRise < 0) checkOutput("firstPressCycle", cyc, 1);
                else checkOutput("riseSpacing", int'((cyc - lastRise) >= 3), 1);
                lastRise = cyc;
            end
            prevKey = cpuKey;
        end

        // Freeze on the second PRESS cycle of a 4-cycle hold
        doReset(9'h1FF);
`ifdef CPU_STATS_EN
        checkOutput("resetCount4", pressCount4, 0);
`endif
        step();
        checkOutput("t4Key1", cpuKey4, 1);
        checkOutput("t4Press1", cpuPress4, 1);
        step();
        checkOutput("t4Key2", cpuKey4, 1);
        checkOutput("t4Press2", cpuPress4, 0);
        applyStimulus(9'h1FF, 1'b1);
        step();
        checkOutput("t4FrzKey", cpuKey4, 0);
        checkOutput("t4FrzPress", cpuPress4, 0);
        checkOutput("t4FrzLfsr", int'(dut4.lfsr_q), 7);
        for (int i = 0; i < 19; i++) begin
            step();
            checkOutput("t4HeldKey", cpuKey4, 0);
            checkOutput("t4HeldPress", cpuPress4, 0);
        end
        applyStimulus(9'h1FF, 1'b0);
        found = 0;
        for (int n = 0; n < 64 && found == 0; n++) begin
            step();
            if (cpuPress4) found = 1;
        end
        checkOutput("t4Resume", found, 1);
        width = 0;
        for (int n = 0; n < 10 && cpuKey4; n++) begin
            width++;
            step();
        end
        checkOutput("t4HoldWidth", width, 4);

        // Reset pulsed during PRESS
        found = 0;
        for (int n = 0; n < 64 && found == 0; n++) begin
            step();
            if (cpuPress4) found = 1;
        end
        checkOutput("t5Press", found, 1);
        step();
        checkOutput("t5KeyBefore", cpuKey4, 1);
        reset = 1'b1;
        step();
        checkOutput("t5Key", cpuKey4, 0);
        checkOutput("t5Press", cpuPress4, 0);
        checkOutput("t5Lfsr0", int'(dut4.lfsr_q), 0);
        reset = 1'b0;
        step();
        checkOutput("t5Lfsr1", int'(dut4.lfsr_q), 1);
        step();
        checkOutput("t5Lfsr3", int'(dut4.lfsr_q), 3);

`ifdef CPU_STATS_EN
        // Press counter tracks pulses and saturates
        doReset(9'h1FF);
        checkOutput("countReset", pressCount, 0);
        pulses = 0;
        for (int i = 0; i < 3000; i++) begin
            step();
            if (cpuPress) pulses++;
            checkOutput("pressCount", pressCount, (pulses > 255) ? 255 : pulses);
        end
        checkOutput("satReached", int'(pulses > 255), 1);
`else
        pulses = 0;
`endif

        $display("[TB] %0d tests run, %0d failed", testsRun, testsFailed);
        $finish;
    end

endmodule
